// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core (initiator) and the memory responder.
interface data_mem_responder_if;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        iWriteEnable;
  logic        iReadEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] oReadData;
  logic        oReady;
  logic        oFault;
  logic        oBusy;

  modport master (
    output iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    input  oReadData, oReady, oFault, oBusy
  );

  modport slave (
    input  iAddress, iWriteData, iWriteEnable, iReadEnable, iByteEnable,
    output oReadData, oReady, oFault, oBusy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: window decode, byte-lane writes, read-before-write
// response after a fixed number of wait states, out-of-window fault flag.
module data_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  data_mem_responder_if.slave bus
);

  localparam int unsigned       IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned       CNT_W    = 3;
  localparam logic [32:0]       LO_33    = {1'b0, ADDR_BASE};
  localparam logic [32:0]       HI_33    = LO_33 + 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LOAD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;

  logic [IDX_W-1:0] cap_idx;
  logic [31:0]      cap_wdata;
  logic [3:0]       cap_be;
  logic             cap_we;
  logic             cap_hit;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             req;
  logic             accept;
  logic             resp_go;
  logic [31:0]      live_off;
  logic [IDX_W-1:0] live_idx;
  logic             live_hit;

  logic [IDX_W-1:0] eff_idx;
  logic [31:0]      eff_wdata;
  logic [3:0]       eff_be;
  logic             eff_we;
  logic             eff_hit;

  // Window decode of the live bus; 33-bit compare so the limit cannot wrap
  always_comb begin
    req      = bus.iReadEnable | bus.iWriteEnable;
    live_off = bus.iAddress - ADDR_BASE;
    live_idx = IDX_W'(live_off >> 2);
    live_hit = ({1'b0, bus.iAddress} >= LO_33) && ({1'b0, bus.iAddress} < HI_33);
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Next-state logic and handshake qualifiers
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          accept     = 1'b1;
          next_state = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: if (cnt == '0) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    resp_go = (next_state == ST_RESP);
  end

  // With no wait states the response is formed from the live bus at acceptance
  always_comb begin
    if (state == ST_IDLE) begin
      eff_idx   = live_idx;
      eff_wdata = bus.iWriteData;
      eff_be    = bus.iByteEnable;
      eff_we    = bus.iWriteEnable;
      eff_hit   = live_hit;
    end else begin
      eff_idx   = cap_idx;
      eff_wdata = cap_wdata;
      eff_be    = cap_be;
      eff_we    = cap_we;
      eff_hit   = cap_hit;
    end
  end

  // Wait-state counter
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)               cnt <= '0;
    else if (accept)           cnt <= CNT_LOAD;
    else if (state == ST_WAIT) cnt <= cnt - CNT_W'(1);
  end

  // Capture the accepted request so the bus is free during the wait
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      cap_we    <= 1'b0;
      cap_hit   <= 1'b0;
    end else if (accept) begin
      cap_idx   <= live_idx;
      cap_wdata <= bus.iWriteData;
      cap_be    <= bus.iByteEnable;
      cap_we    <= bus.iWriteEnable;
      cap_hit   <= live_hit;
    end
  end

  // Storage: byte-lane write on the edge that enters the response cycle
  always_ff @(posedge iCLK) begin
    if (iRST_N && resp_go && eff_we && eff_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_be[b]) mem[eff_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
      end
    end
  end

  // Registered response; read data is the pre-write word and is held
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bus.oReadData <= '0;
      bus.oReady    <= 1'b0;
      bus.oFault    <= 1'b0;
      bus.oBusy     <= 1'b0;
    end else begin
      bus.oReady <= resp_go;
      bus.oFault <= resp_go && !eff_hit;
      bus.oBusy  <= (next_state == ST_WAIT);
      if (resp_go) bus.oReadData <= eff_hit ? mem[eff_idx] : 32'h0;
    end
  end

endmodule
